// File: rtl/inject_vc_scheduler.sv
// Injection-side VC allocator and flit scheduler: round-robin over virtual
// networks, per-VC credit tracking, header/tail packet ownership of VCs.
module inject_vc_scheduler #(
    parameter  int NUM_VN         = 3,
    parameter  int NUM_VC         = 1,
    parameter  int FLIT_TYPE_SIZE = 2,
    parameter  int CREDITS        = 4,
    localparam int NUM_VN_X_VC    = NUM_VN * NUM_VC,
    localparam int VCW            = (NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1
) (
    input  logic                             clk,
    input  logic                             rst_p,
    input  logic [NUM_VN-1:0]                req,
    input  logic [NUM_VN*FLIT_TYPE_SIZE-1:0] req_flit_type,
    input  logic                             credit_valid,
    input  logic [VCW-1:0]                   credit_vc,
    output logic [NUM_VN_X_VC-1:0]           GRANTS,
    output logic [VCW-1:0]                   vc_selected,
    output logic [NUM_VN-1:0]                pop,
    output logic                             err
);

    localparam int CW  = $clog2(CREDITS + 1);
    localparam int LVW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int RW  = (NUM_VN > 1) ? $clog2(NUM_VN) : 1;

    localparam logic [FLIT_TYPE_SIZE-1:0] FT_BODY   = FLIT_TYPE_SIZE'(0);
    localparam logic [FLIT_TYPE_SIZE-1:0] FT_TAIL   = FLIT_TYPE_SIZE'(1);
    localparam logic [FLIT_TYPE_SIZE-1:0] FT_HEADER = FLIT_TYPE_SIZE'(2);
    localparam logic [FLIT_TYPE_SIZE-1:0] FT_HDRTL  = FLIT_TYPE_SIZE'(3);

    typedef enum logic {
        VC_FREE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    vc_state_e         vc_st_q  [NUM_VN_X_VC];
    vc_state_e         vc_st_d  [NUM_VN_X_VC];
    logic [CW-1:0]     credit_q [NUM_VN_X_VC];
    logic [CW-1:0]     credit_d [NUM_VN_X_VC];
    logic [NUM_VN-1:0] in_pkt_q;
    logic [NUM_VN-1:0] in_pkt_d;
    logic [LVW-1:0]    own_q    [NUM_VN];
    logic [LVW-1:0]    own_d    [NUM_VN];
    logic [RW-1:0]     rr_q;
    logic [RW-1:0]     rr_d;
    logic              err_q;
    logic              err_d;

    logic [NUM_VN_X_VC-1:0] vc_free;
    logic [NUM_VN_X_VC-1:0] cr_nz;

    logic [NUM_VN-1:0] is_hdr;
    logic [NUM_VN-1:0] is_tl;
    logic [NUM_VN-1:0] hdr_ok;
    logic [NUM_VN-1:0] elig;
    logic [NUM_VN-1:0] perr;
    logic [LVW-1:0]    hdr_sel [NUM_VN];
    logic [VCW-1:0]    hdr_g   [NUM_VN];
    logic [VCW-1:0]    own_g   [NUM_VN];

    logic              found;
    logic              grant_en;
    logic [RW-1:0]     win;
    logic [VCW-1:0]    gvc;
    logic [LVW-1:0]    g_lvc;
    logic              g_hdr;
    logic              g_tl;

    always_comb begin
        vc_free = '0;
        cr_nz   = '0;
        for (int x = 0; x < NUM_VN_X_VC; x++) begin
            vc_free[x] = (vc_st_q[x] == VC_FREE);
            cr_nz[x]   = (credit_q[x] != '0);
        end
    end

    for (genvar v = 0; v < NUM_VN; v++) begin : g_vn
        logic [FLIT_TYPE_SIZE-1:0] ft;
        logic                      hok;
        logic [LVW-1:0]            hsel;

        assign ft        = req_flit_type[v*FLIT_TYPE_SIZE +: FLIT_TYPE_SIZE];
        assign is_hdr[v] = (ft == FT_HEADER) || (ft == FT_HDRTL);
        assign is_tl[v]  = (ft == FT_TAIL) || (ft == FT_HDRTL);

        // Lowest-indexed free VC of this VN that still holds credit
        always_comb begin
            hok  = 1'b0;
            hsel = '0;
            for (int c = NUM_VC - 1; c >= 0; c--) begin
                if (vc_free[v*NUM_VC+c] && cr_nz[v*NUM_VC+c]) begin
                    hok  = 1'b1;
                    hsel = LVW'(c);
                end
            end
        end

        assign hdr_ok[v]  = hok;
        assign hdr_sel[v] = hsel;
        assign hdr_g[v]   = VCW'(v * NUM_VC) + VCW'(hsel);
        assign own_g[v]   = VCW'(v * NUM_VC) + VCW'(own_q[v]);

        assign elig[v] = req[v] &&
                         (is_hdr[v] ? (!in_pkt_q[v] && hok)
                                    : (in_pkt_q[v] && cr_nz[own_g[v]]));
        assign perr[v] = req[v] && (is_hdr[v] ? in_pkt_q[v] : !in_pkt_q[v]);
    end

    // Winner is the eligible VN at the smallest rotational distance from rr
    always_comb begin
        int best;
        int d;
        found = 1'b0;
        win   = '0;
        gvc   = '0;
        g_lvc = '0;
        g_hdr = 1'b0;
        g_tl  = 1'b0;
        best  = NUM_VN;
        for (int v = 0; v < NUM_VN; v++) begin
            d = v - int'(rr_q);
            if (d < 0) begin
                d = d + NUM_VN;
            end
            if (elig[v] && (d < best)) begin
                best  = d;
                found = 1'b1;
                win   = RW'(v);
                gvc   = is_hdr[v] ? hdr_g[v] : own_g[v];
                g_lvc = is_hdr[v] ? hdr_sel[v] : own_q[v];
                g_hdr = is_hdr[v];
                g_tl  = is_tl[v];
            end
        end
    end

    assign grant_en = found && !rst_p;

    always_comb begin
        GRANTS      = '0;
        vc_selected = '0;
        pop         = '0;
        if (grant_en) begin
            GRANTS[gvc] = 1'b1;
            vc_selected = gvc;
            pop[win]    = 1'b1;
        end
    end

    always_comb begin
        logic inc;
        logic dec;
        vc_st_d  = vc_st_q;
        credit_d = credit_q;
        in_pkt_d = in_pkt_q;
        own_d    = own_q;
        rr_d     = rr_q;
        err_d    = err_q || (|perr);
        inc      = 1'b0;
        dec      = 1'b0;

        if (grant_en) begin
            rr_d = (win == RW'(NUM_VN - 1)) ? '0 : win + RW'(1);
            if (g_hdr && !g_tl) begin
                vc_st_d[gvc]  = VC_BUSY;
                in_pkt_d[win] = 1'b1;
                own_d[win]    = g_lvc;
            end else if (g_tl && !g_hdr) begin
                vc_st_d[gvc]  = VC_FREE;
                in_pkt_d[win] = 1'b0;
            end
        end

        for (int x = 0; x < NUM_VN_X_VC; x++) begin
            inc = credit_valid && (credit_vc == VCW'(x));
            dec = grant_en && (gvc == VCW'(x));
            if (inc && !dec) begin
                if (credit_q[x] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[x] = credit_q[x] + CW'(1);
                end
            end else if (dec && !inc) begin
                credit_d[x] = credit_q[x] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            for (int x = 0; x < NUM_VN_X_VC; x++) begin
                vc_st_q[x]  <= VC_FREE;
                credit_q[x] <= CW'(CREDITS);
            end
            for (int v = 0; v < NUM_VN; v++) begin
                own_q[v] <= '0;
            end
            in_pkt_q <= '0;
            rr_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            vc_st_q  <= vc_st_d;
            credit_q <= credit_d;
            in_pkt_q <= in_pkt_d;
            own_q    <= own_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_inject_vc_scheduler.sv
// Bench for inject_vc_scheduler: directed table, corner sequences and a
// randomized run against a packet-level reference model.
module tb_inject_vc_scheduler;

    logic       clk;
    logic       rst_p;
    logic [2:0] req;
    logic [5:0] req_flit_type;
    logic       credit_valid;
    logic [2:0] credit_vc;
    logic [5:0] GRANTS;
    logic [2:0] vc_selected;
    logic [2:0] pop;
    logic       err;

    inject_vc_scheduler #(
        .NUM_VN(3),
        .NUM_VC(2),
        .FLIT_TYPE_SIZE(2),
        .CREDITS(4)
    ) dut (
        .clk(clk),
        .rst_p(rst_p),
        .req(req),
        .req_flit_type(req_flit_type),
        .credit_valid(credit_valid),
        .credit_vc(credit_vc),
        .GRANTS(GRANTS),
        .vc_selected(vc_selected),
        .pop(pop),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [5:0] s_grants;
    logic [2:0] s_pop;
    logic       s_err;

    bit m_busy  [6];
    int m_cred  [6];
    bit m_inpkt [3];
    int m_own   [3];
    int m_rr;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int x = 0; x < 6; x++) begin
            m_busy[x] = 1'b0;
            m_cred[x] = 4;
        end
        for (int v = 0; v < 3; v++) begin
            m_inpkt[v] = 1'b0;
            m_own[v]   = 0;
        end
        m_rr  = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_eval(input bit r, input logic [2:0] rq,
                                       input logic [5:0] f, output bit g,
                                       output int gvn, output int gvc);
        g   = 1'b0;
        gvn = 0;
        gvc = 0;
        if (r) return;
        for (int i = 0; i < 3; i++) begin
            int v;
            int t;
            v = (m_rr + i) % 3;
            t = int'(f[2*v +: 2]);
            if (!g && rq[v]) begin
                if (t >= 2) begin
                    if (!m_inpkt[v]) begin
                        for (int c = 0; c < 2; c++) begin
                            if (!g && !m_busy[v*2+c] && m_cred[v*2+c] > 0) begin
                                g   = 1'b1;
                                gvn = v;
                                gvc = v * 2 + c;
                            end
                        end
                    end
                end else if (m_inpkt[v] && m_cred[m_own[v]] > 0) begin
                    g   = 1'b1;
                    gvn = v;
                    gvc = m_own[v];
                end
            end
        end
    endfunction

    function automatic void model_update(input bit r, input logic [2:0] rq,
                                         input logic [5:0] f, input bit cv,
                                         input logic [2:0] cvc);
        bit g;
        int gvn;
        int gvc;
        int t;
        int cx;
        if (r) begin
            model_reset();
            return;
        end
        model_eval(r, rq, f, g, gvn, gvc);
        for (int v = 0; v < 3; v++) begin
            t = int'(f[2*v +: 2]);
            if (rq[v] && ((t >= 2) == m_inpkt[v])) m_err = 1'b1;
        end
        if (g) begin
            m_rr = (gvn + 1) % 3;
            m_cred[gvc] = m_cred[gvc] - 1;
            t = int'(f[2*gvn +: 2]);
            if (t == 2) begin
                m_busy[gvc]  = 1'b1;
                m_inpkt[gvn] = 1'b1;
                m_own[gvn]   = gvc;
            end else if (t == 1) begin
                m_busy[gvc]  = 1'b0;
                m_inpkt[gvn] = 1'b0;
            end
        end
        if (cv) begin
            cx = int'(cvc);
            if (g && gvc == cx) m_cred[cx] = m_cred[cx] + 1;
            else if (m_cred[cx] == 4) m_err = 1'b1;
            else m_cred[cx] = m_cred[cx] + 1;
        end
    endfunction

    task automatic step(input bit r, input logic [2:0] rq, input logic [5:0] f,
                        input bit cv, input logic [2:0] cvc, output bit g,
                        output int gvn, output int gvc);
        logic [5:0] eg;
        logic [2:0] ep;
        logic [2:0] es;
        rst_p         = r;
        req           = rq;
        req_flit_type = f;
        credit_valid  = cv;
        credit_vc     = cvc;
        @(negedge clk);
        model_eval(r, rq, f, g, gvn, gvc);
        eg = g ? (6'd1 << gvc) : 6'd0;
        ep = g ? (3'd1 << gvn) : 3'd0;
        es = g ? 3'(gvc) : 3'd0;
        s_grants = GRANTS;
        s_pop    = pop;
        s_err    = err;
        if (chk_en) begin
            chk("mdl_grants", GRANTS, eg);
            chk("mdl_vcsel", vc_selected, es);
            chk("mdl_pop", pop, ep);
            chk("mdl_err", err, m_err);
        end
        @(posedge clk);
        model_update(r, rq, f, cv, cvc);
        #1;
    endtask

    task automatic restore();
        bit g;
        int a;
        int b;
        for (int x = 0; x < 6; x++) begin
            while (m_cred[x] < 4) step(0, 3'b000, 6'b0, 1, 3'(x), g, a, b);
        end
    endtask

    typedef struct {
        bit         r;
        logic [2:0] rq;
        logic [5:0] f;
        bit         cv;
        logic [2:0] cvc;
        logic [5:0] eg;
        logic [2:0] ep;
    } vec_t;

    vec_t tbl [23];

    initial begin
        bit g;
        int gvn;
        int gvc;
        int n;
        int sent;
        int due[$];

        tbl[0]  = '{1'b1, 3'b111, 6'b111111, 1'b0, 3'd0, 6'b000000, 3'b000};
        tbl[1]  = '{1'b0, 3'b111, 6'b111111, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[2]  = '{1'b0, 3'b111, 6'b111111, 1'b0, 3'd0, 6'b000100, 3'b010};
        tbl[3]  = '{1'b0, 3'b111, 6'b111111, 1'b0, 3'd0, 6'b010000, 3'b100};
        tbl[4]  = '{1'b0, 3'b111, 6'b111111, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[5]  = '{1'b0, 3'b001, 6'b000011, 1'b1, 3'd0, 6'b000001, 3'b001};
        tbl[6]  = '{1'b0, 3'b000, 6'b000000, 1'b1, 3'd2, 6'b000000, 3'b000};
        tbl[7]  = '{1'b0, 3'b000, 6'b000000, 1'b1, 3'd4, 6'b000000, 3'b000};
        tbl[8]  = '{1'b0, 3'b000, 6'b000000, 1'b1, 3'd0, 6'b000000, 3'b000};
        tbl[9]  = '{1'b0, 3'b000, 6'b000000, 1'b1, 3'd0, 6'b000000, 3'b000};
        tbl[10] = '{1'b0, 3'b000, 6'b000000, 1'b0, 3'd0, 6'b000000, 3'b000};
        tbl[11] = '{1'b0, 3'b001, 6'b000010, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[12] = '{1'b0, 3'b001, 6'b000000, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[13] = '{1'b0, 3'b001, 6'b000000, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[14] = '{1'b0, 3'b001, 6'b000001, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[15] = '{1'b0, 3'b001, 6'b000010, 1'b0, 3'd0, 6'b000010, 3'b001};
        tbl[16] = '{1'b0, 3'b001, 6'b000001, 1'b0, 3'd0, 6'b000010, 3'b001};
        tbl[17] = '{1'b0, 3'b001, 6'b000010, 1'b1, 3'd0, 6'b000010, 3'b001};
        tbl[18] = '{1'b0, 3'b001, 6'b000001, 1'b0, 3'd0, 6'b000010, 3'b001};
        tbl[19] = '{1'b0, 3'b001, 6'b000010, 1'b0, 3'd0, 6'b000001, 3'b001};
        tbl[20] = '{1'b0, 3'b001, 6'b000001, 1'b0, 3'd0, 6'b000000, 3'b000};
        tbl[21] = '{1'b0, 3'b001, 6'b000001, 1'b1, 3'd0, 6'b000000, 3'b000};
        tbl[22] = '{1'b0, 3'b001, 6'b000001, 1'b0, 3'd0, 6'b000001, 3'b001};

        model_reset();
        step(1, 3'b000, 6'b0, 0, 3'd0, g, gvn, gvc);
        step(1, 3'b000, 6'b0, 0, 3'd0, g, gvn, gvc);
        chk_en = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].rq, tbl[i].f, tbl[i].cv, tbl[i].cvc, g, gvn, gvc);
            chk($sformatf("tbl%0d_grants", i), s_grants, tbl[i].eg);
            chk($sformatf("tbl%0d_pop", i), s_pop, tbl[i].ep);
            chk($sformatf("tbl%0d_err", i), s_err, 1'b0);
        end
        restore();

        // Six-flit packet on VN1 starting from a nearly drained VC
        for (int i = 0; i < 3; i++) step(0, 3'b010, 6'b001100, 0, 3'd0, g, gvn, gvc);
        restore();
        for (int i = 0; i < 3; i++) step(0, 3'b010, 6'b001100, 0, 3'd0, g, gvn, gvc);
        chk("vc2_drained", m_cred[2], 1);
        sent = 0;
        for (n = 0; n < 60 && sent < 6; n++) begin
            bit cv;
            logic [1:0] ft;
            cv = 1'b0;
            if (due.size() > 0 && due[0] == n) begin
                cv = 1'b1;
                void'(due.pop_front());
            end
            ft = (sent == 0) ? 2'b10 : (sent == 5) ? 2'b01 : 2'b00;
            step(0, 3'b010, {2'b00, ft, 2'b00}, cv, 3'd2, g, gvn, gvc);
            if (g) begin
                sent++;
                due.push_back(n + 2);
            end
        end
        chk("pkt6_sent", sent, 6);
        chk("pkt6_cycles", n, 16);
        restore();

        // Body on VN2 outside a packet, then surplus credit at full count
        step(0, 3'b100, 6'b000000, 0, 3'd0, g, gvn, gvc);
        chk("stray_body_grants", s_grants, 6'b0);
        chk("stray_body_pop", s_pop, 3'b0);
        step(0, 3'b000, 6'b0, 1, 3'd4, g, gvn, gvc);
        chk("err_set", s_err, 1'b1);
        step(0, 3'b000, 6'b0, 0, 3'd0, g, gvn, gvc);
        chk("err_sticky", s_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'b100, 6'b110000, 0, 3'd0, g, gvn, gvc);
            chk($sformatf("vc4_ht%0d", i), s_grants, 6'b010000);
        end
        step(0, 3'b100, 6'b110000, 0, 3'd0, g, gvn, gvc);
        chk("vc4_saturated", s_grants, 6'b100000);
        restore();

        // Reset in the middle of a VN0 packet
        step(0, 3'b001, 6'b000010, 0, 3'd0, g, gvn, gvc);
        chk("midpkt_hdr", s_grants, 6'b000001);
        step(1, 3'b001, 6'b000000, 1, 3'd0, g, gvn, gvc);
        chk("rst_grants", s_grants, 6'b0);
        chk("rst_pop", s_pop, 3'b0);
        step(0, 3'b000, 6'b0, 0, 3'd0, g, gvn, gvc);
        chk("post_rst_err", s_err, 1'b0);
        chk("post_rst_grants", s_grants, 6'b0);
        step(0, 3'b001, 6'b000010, 0, 3'd0, g, gvn, gvc);
        chk("post_rst_hdr", s_grants, 6'b000001);
        step(0, 3'b001, 6'b000001, 0, 3'd0, g, gvn, gvc);
        step(0, 3'b000, 6'b0, 0, 3'd0, g, gvn, gvc);
        chk("post_rst_noerr", s_err, 1'b0);

        for (int i = 0; i < 400; i++) begin
            bit r;
            bit cv;
            logic [2:0] rq;
            logic [5:0] f;
            int x;
            r  = ($urandom_range(0, 60) == 0);
            rq = 3'($urandom);
            f  = '0;
            for (int v = 0; v < 3; v++) begin
                f[2*v +: 2] = m_inpkt[v] ? 2'($urandom_range(0, 1))
                                         : 2'($urandom_range(2, 3));
            end
            x  = $urandom_range(0, 5);
            cv = (m_cred[x] < 4) && ($urandom_range(0, 1) == 1);
            step(r, rq, f, cv, 3'(x), g, gvn, gvc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inject_vc_scheduler.md
INJECT_VC_SCHEDULER -- requirements
Module: inject_vc_scheduler

Interface
REQ-001 Parameter NUM_VN, default 3: number of virtual networks.
REQ-002 Parameter NUM_VC, default 1: virtual channels per VN; NUM_VN_X_VC = NUM_VN*NUM_VC.
REQ-003 Parameter FLIT_TYPE_SIZE, default 2: flit type width; header/body/tail/header_tail encodings per network common definitions.
REQ-004 Parameter CREDITS, default 4: downstream buffer slots per VC; counter width clog2(CREDITS+1).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_p  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_VN  per-VN injection queue non-empty.
REQ-008 req_flit_type  input  NUM_VN*FLIT_TYPE_SIZE  head-flit type per VN, VN v at slice v.
REQ-009 credit_valid  input  1  one credit returned from downstream this cycle.
REQ-010 credit_vc  input  bits_VN_X_VC  global VC index of returned credit.
REQ-011 GRANTS  output  NUM_VN_X_VC  one-hot grant, bit vn*NUM_VC+vc; zero when idle.
REQ-012 vc_selected  output  bits_VN_X_VC  binary index of the GRANTS bit; zero when idle.
REQ-013 pop  output  NUM_VN  one-hot dequeue to the granted VN queue.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 GRANTS, vc_selected, pop shall be combinational from current state and inputs (zero added latency); downstream output stage registers them.
REQ-016 Per VC: state FREE/BUSY, credit counter; per VN: in_packet flag, owned-VC register.
REQ-017 VN v eligible with header or header_tail head: req[v]=1, in_packet[v]=0, and some VC of VN v is FREE with credit>0; selected VC = lowest such index.
REQ-018 VN v eligible with body or tail head: req[v]=1, in_packet[v]=1, owned VC credit>0.
REQ-019 Body/tail with in_packet=0, or header with in_packet=1: VN ineligible, err set, held until reset.
REQ-020 At most one grant per cycle; round-robin among eligible VNs starting at pointer rr; after a grant rr = (winner+1) mod NUM_VN; no grant leaves rr unchanged.
REQ-021 Header grant: VC to BUSY, in_packet=1, owned VC recorded, next edge.
REQ-022 Tail grant: VC to FREE, in_packet=0 next edge; header_tail grant leaves VC FREE, in_packet=0.
REQ-023 Granted VC credit decrements by 1; credit_valid increments credit_vc; both on same VC same cycle: unchanged.
REQ-024 Credit return to a VC already at CREDITS (without simultaneous grant): counter saturates, err set.
REQ-025 A VC freed by a tail grant is allocatable no earlier than the following cycle.
REQ-026 Credit for VC x arriving in the cycle VC x has credit 0 does not make it eligible that cycle.

Reset
REQ-027 On rst_p=1 at a clock edge: all VCs FREE, credits=CREDITS, in_packet=0, owned VC=0, rr=0, err=0.
REQ-028 While rst_p=1: GRANTS=0, vc_selected=0, pop=0 regardless of inputs; reset mid-packet discards packet state.

Verification (NUM_VN=3, NUM_VC=2, CREDITS=4)
REQ-029 Reset, req=3'b111 all header_tail -> grants VN0,VN1,VN2,VN0 on cycles 1-4; GRANTS 6'b000001, 6'b000100, 6'b010000, 6'b000001.
REQ-030 VN0 header, body, body, tail, no credits returned -> VC0 granted 4 cycles; credits VC0 4->0; VC0 FREE after tail; next VN0 header uses VC0 only after credit return, else VC1.
REQ-031 VN1 packet of 6 flits, credit returned 2 cycles after each grant -> stall at credit 0, resumes the cycle after credit edge; no grant while credit=0.
REQ-032 Grant and credit_valid on same VC same cycle at credit 2 -> credit stays 2, err=0.
REQ-033 VN2 body flit with in_packet=0 -> no grant, err=1 persists; extra credit_valid at credit 4 -> credit stays 4.
REQ-034 rst_p asserted mid-packet on VN0 -> next cycle all outputs 0; after release VN0 header accepted without err.
